// File: rtl/suba_in_arbiter.sv
// Round-robin burst arbiter sharing subA's in_bit1 among NUM_REQ requesters.
// Optional grant statistics counter enabled by defining SUBA_ARB_STATS_EN.
module suba_in_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 8,
  parameter int GAP       = 2
`ifdef SUBA_ARB_STATS_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_bit,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       in_bit1,
  output logic                       busy,
`ifdef SUBA_ARB_STATS_EN
  output logic [NUM_REQ-1:0]         done,
  output logic [CNT_W-1:0]           grant_total
`else
  output logic [NUM_REQ-1:0]         done
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(BURST_LEN + 1);
  localparam int GW    = (GAP < 1) ? 1 : $clog2(GAP + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               in_bit1_q, in_bit1_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic               start;

  // First set request at or above ptr, wrapping back to index 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && r[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    logic [IDX_W-1:0] sel;
    logic             burst_end;
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    in_bit1_d   = 1'b0;
    done_d      = '0;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    start       = 1'b0;
    sel         = rr_pick(req, rr_ptr_q);
    burst_end   = (burst_cnt_q == BC_W'(BURST_LEN - 1)) || !req[owner_q];
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
          owner_d     = sel;
          burst_cnt_d = '0;
          state_d     = ST_BURST;
          start       = 1'b1;
        end
      end
      ST_BURST: begin
        // A dropped request is not a data cycle, even if the limit is hit too.
        if (req[owner_q]) in_bit1_d = req_bit[owner_q];
        if (burst_end) begin
          gnt_d    = '0;
          owner_d  = '0;
          done_d   = gnt_q;
          rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          burst_cnt_d = burst_cnt_q + BC_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP - 1)) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      in_bit1_q   <= 1'b0;
      done_q      <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      in_bit1_q   <= in_bit1_d;
      done_q      <= done_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

`ifdef SUBA_ARB_STATS_EN
  logic [CNT_W-1:0] grant_total_q, grant_total_d;

  always_comb begin
    grant_total_d = grant_total_q;
    if (start && (grant_total_q != {CNT_W{1'b1}})) grant_total_d = grant_total_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) grant_total_q <= '0;
    else        grant_total_q <= grant_total_d;
  end

  assign grant_total = grant_total_q;
`endif

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign in_bit1 = in_bit1_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_suba_in_arbiter.sv
// Scoreboard bench for suba_in_arbiter: a transaction-level model predicts every
// cycle's outputs, and a monitor compares them one cycle later.
module tb_suba_in_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int BURST_LEN = 8;
  localparam int GAP       = 2;
  localparam int CNT_W     = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] req_bit = '0;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         owner;
  logic               in_bit1;
  logic               busy;
  logic [NUM_REQ-1:0] done;
`ifdef SUBA_ARB_STATS_EN
  logic [CNT_W-1:0]   grant_total;
`endif

  always #5 clk = ~clk;

  suba_in_arbiter #(
    .NUM_REQ(NUM_REQ),
    .BURST_LEN(BURST_LEN),
    .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_bit(req_bit),
    .gnt(gnt),
    .owner(owner),
    .in_bit1(in_bit1),
    .busy(busy),
`ifdef SUBA_ARB_STATS_EN
    .done(done),
    .grant_total(grant_total)
`else
    .done(done)
`endif
  );

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         owner;
    logic               in_bit1;
    logic               busy;
    logic [NUM_REQ-1:0] done;
    int                 total;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Model state: current owner (-1 when none), cycles held, gap cycles left.
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_ptr   = 0;
  int m_total = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d actual %0h expected %0h", name, cycle, act, expv);
    end
  endtask

  // Drive one cycle of inputs and push the predicted post-edge outputs.
  task automatic applyStimulus(input logic rst, input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] b);
    exp_t e;
    logic rel;
    logic found;
    int   c;
    @(negedge clk);
    rst_n     = rst;
    req       = r;
    req_bit   = b;
    e.done    = '0;
    e.in_bit1 = 1'b0;
    rel       = 1'b0;
    if (!rst) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_total = 0;
    end else if (m_owner >= 0) begin
      if (!r[m_owner]) rel = 1'b1;
      else begin
        e.in_bit1 = b[m_owner];
        m_held++;
        if (m_held == BURST_LEN) rel = 1'b1;
      end
      if (rel) begin
        e.done  = NUM_REQ'(1 << m_owner);
        m_ptr   = (m_owner + 1) % NUM_REQ;
        m_gap   = GAP;
        m_owner = -1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (r != '0) begin
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (m_ptr + k) % NUM_REQ;
        if (!found && r[c]) begin
          m_owner = c;
          found   = 1'b1;
        end
      end
      m_held = 0;
      if (m_total < (1 << CNT_W) - 1) m_total++;
    end
    e.gnt   = (m_owner >= 0) ? NUM_REQ'(1 << m_owner) : '0;
    e.owner = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.busy  = (m_owner >= 0) || (m_gap > 0);
    e.total = m_total;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest prediction just after each edge.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("gnt", 32'(gnt), 32'(mon_e.gnt));
      checkOutput("owner", 32'(owner), 32'(mon_e.owner));
      checkOutput("in_bit1", 32'(in_bit1), 32'(mon_e.in_bit1));
      checkOutput("busy", 32'(busy), 32'(mon_e.busy));
      checkOutput("done", 32'(done), 32'(mon_e.done));
`ifdef SUBA_ARB_STATS_EN
      checkOutput("grant_total", 32'(grant_total), 32'(mon_e.total));
`endif
    end
  end

  initial begin
    logic [NUM_REQ-1:0] r;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1111, 4'($urandom));
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 4'b0100, 4'b0100);
    for (int i = 0; i < 60; i++) applyStimulus(1'b1, 4'b1111, 4'($urandom));
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4'b0000, 4'b1111);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0010, 4'b0010);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'b0000, 4'b1111);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b1110, 4'b1111);
    applyStimulus(1'b0, 4'b1110, 4'b1111);
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 4'b1111, 4'($urandom));
    r = 4'b1010;
    for (int i = 0; i < 2000; i++) begin
      for (int j = 0; j < NUM_REQ; j++)
        if ($urandom_range(0, 7) == 0) r[j] = ~r[j];
      applyStimulus(($urandom_range(0, 299) != 0), r, 4'($urandom));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
